// File: rtl/fpu_vector_fetch.sv
// Consumer stage for a ripple-counter address bus: resynchronise and filter the address,
// queue each new settled value, fetch its operand/opcode vector and present it on valid/ready.
module fpu_vector_fetch #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 3,
  parameter int QDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 addr_i,
  input  logic                       wr_en_i,
  input  logic [4:0]                 wr_addr_i,
  input  logic [2*DATA_W+OPC_W-1:0]  wr_data_i,
  input  logic                       vec_ready_i,
  output logic                       vec_valid_o,
  output logic [4:0]                 vec_addr_o,
  output logic [DATA_W-1:0]          op_a_o,
  output logic [DATA_W-1:0]          op_b_o,
  output logic [OPC_W-1:0]           opcode_o,
  output logic                       ovf_o
);

  localparam int WORD_W = 2*DATA_W + OPC_W;
  localparam int QW     = $clog2(QDEPTH);
  localparam int CW     = QW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  logic [4:0]        s1_r, s2_r, s3_r;
  logic [2:0]        fill_r;
  logic [4:0]        last_addr_r;
  logic              last_valid_r;
  logic              stable_s, accept_s;

  logic [4:0]        q_mem_r [QDEPTH];
  logic [QW-1:0]     head_r, tail_r;
  logic [CW-1:0]     count_r;
  logic              empty_s, full_s, push_ok_s, pop_s, drop_s;
  logic [4:0]        head_addr_s;

  logic [WORD_W-1:0] tbl_r [32];

  state_t            state_r, state_nx_s;

  // fill_r marks which sync stages hold a post-reset sample, so the reset value of the
  // sync flops is never mistaken for a settled address.
  assign stable_s    = fill_r[2] && (s2_r == s3_r);
  assign accept_s    = stable_s && (!last_valid_r || (s2_r != last_addr_r));
  assign empty_s     = (count_r == {CW{1'b0}});
  assign full_s      = (count_r == CW'(QDEPTH));
  assign pop_s       = (state_r == READ) && !empty_s;
  assign push_ok_s   = accept_s && (!full_s || pop_s);
  assign drop_s      = accept_s && full_s && !pop_s;
  assign head_addr_s = q_mem_r[head_r];

  // Address resynchroniser and new-address detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_r         <= 5'd0;
      s2_r         <= 5'd0;
      s3_r         <= 5'd0;
      fill_r       <= 3'b000;
      last_addr_r  <= 5'd0;
      last_valid_r <= 1'b0;
    end else begin
      s1_r   <= addr_i;
      s2_r   <= s1_r;
      s3_r   <= s2_r;
      fill_r <= {fill_r[1:0], 1'b1};
      if (accept_s) begin
        last_addr_r  <= s2_r;
        last_valid_r <= 1'b1;
      end
    end
  end

  // Pending-address queue pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= {QW{1'b0}};
      tail_r  <= {QW{1'b0}};
      count_r <= {CW{1'b0}};
      ovf_o   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        tail_r <= tail_r + QW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + QW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        ovf_o <= 1'b1;
      end
    end
  end

  // Queue storage; contents are only meaningful below count_r.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      q_mem_r[tail_r] <= s2_r;
    end
  end

  // Vector table write port; the read in READ sees pre-write contents on a same-index collision.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tbl_r[wr_addr_i] <= wr_data_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state; IDLE also reacts to an address being accepted this cycle to save a cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (!empty_s || accept_s) begin
          state_nx_s = READ;
        end else begin
          state_nx_s = IDLE;
        end
      end
      READ: begin
        state_nx_s = PRESENT;
      end
      PRESENT: begin
        if (vec_ready_i) begin
          if (!empty_s) begin
            state_nx_s = READ;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = PRESENT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Presented vector: loaded only while leaving READ, so it is frozen throughout PRESENT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_valid_o <= 1'b0;
      vec_addr_o  <= 5'd0;
      op_a_o      <= {DATA_W{1'b0}};
      op_b_o      <= {DATA_W{1'b0}};
      opcode_o    <= {OPC_W{1'b0}};
    end else begin
      vec_valid_o <= (state_nx_s == PRESENT);
      if (state_r == READ) begin
        vec_addr_o                     <= head_addr_s;
        {opcode_o, op_a_o, op_b_o}     <= tbl_r[head_addr_s];
      end
    end
  end

endmodule

// File: tb/tb_fpu_vector_fetch.sv
// Scoreboard bench for fpu_vector_fetch: expected vectors are queued as addresses are driven
// and compared when the DUT completes a valid/ready handshake.
module tb_fpu_vector_fetch;

  localparam int DW = 32;
  localparam int OW = 3;
  localparam int WW = 2*DW + OW;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    addr_i;
  logic          wr_en_i;
  logic [4:0]    wr_addr_i;
  logic [WW-1:0] wr_data_i;
  logic          vec_ready_i;
  logic          vec_valid_o;
  logic [4:0]    vec_addr_o;
  logic [DW-1:0] op_a_o;
  logic [DW-1:0] op_b_o;
  logic [OW-1:0] opcode_o;
  logic          ovf_o;

  typedef struct {
    logic [4:0]    a;
    logic [WW-1:0] w;
  } exp_t;

  exp_t          exp_q[$];
  logic [WW-1:0] mt [32];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_hs  = 0;

  fpu_vector_fetch #(.DATA_W(DW), .OPC_W(OW), .QDEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr_i     (addr_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .vec_ready_i(vec_ready_i),
    .vec_valid_o(vec_valid_o),
    .vec_addr_o (vec_addr_o),
    .op_a_o     (op_a_o),
    .op_b_o     (op_b_o),
    .opcode_o   (opcode_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [WW-1:0] rnd_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[WW-1:0];
  endfunction

  // Handshake monitor: every accepted vector must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && vec_valid_o && vec_ready_i) begin
      exp_t e;
      n_hs++;
      if (exp_q.size() == 0) begin
        chk("spurious_vec", 64'(vec_valid_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("vec_addr", 64'(vec_addr_o), 64'(e.a));
        chk("op_a",     64'(op_a_o),     64'(e.w[63:32]));
        chk("op_b",     64'(op_b_o),     64'(e.w[31:0]));
        chk("opcode",   64'(opcode_o),   64'(e.w[66:64]));
      end
    end
  end

  task automatic expect_vec(input logic [4:0] a);
    exp_t e;
    e.a = a;
    e.w = mt[a];
    exp_q.push_back(e);
  endtask

  task automatic tbl_write(input logic [4:0] idx, input logic [WW-1:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = idx;
    wr_data_i = d;
    mt[idx]   = d;
    @(posedge clk); #1;
    wr_en_i   = 1'b0;
  endtask

  // Reset with addr_i already at a; that address will be fetched once after release.
  task automatic do_reset(input logic [4:0] a);
    rst    = 1'b0;
    addr_i = a;
    exp_q.delete();
    expect_vec(a);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic step(input logic [4:0] a, input int cyc, input bit exp_it);
    addr_i = a;
    if (exp_it) expect_vec(a);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int maxc);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < maxc) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (8) @(posedge clk);
    #1;
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int base;
    logic [WW-1:0] nw;

    rst = 1'b0; addr_i = 5'd0; wr_en_i = 1'b0; wr_addr_i = 5'd0;
    wr_data_i = '0; vec_ready_i = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) tbl_write(5'(i), rnd_word());

    chk("rst_valid",  64'(vec_valid_o), 64'd0);
    chk("rst_addr",   64'(vec_addr_o),  64'd0);
    chk("rst_op_a",   64'(op_a_o),      64'd0);
    chk("rst_op_b",   64'(op_b_o),      64'd0);
    chk("rst_opcode", 64'(opcode_o),    64'd0);
    chk("rst_ovf",    64'(ovf_o),       64'd0);

    // 1: single address held from reset, latency of five cycles.
    vec_ready_i = 1'b1;
    do_reset(5'd0);
    repeat (4) @(posedge clk); #1;
    chk("t1_lat4_valid", 64'(vec_valid_o), 64'd0);
    @(posedge clk); #1;
    chk("t1_lat5_valid", 64'(vec_valid_o), 64'd1);
    chk("t1_lat5_addr",  64'(vec_addr_o),  64'd0);
    drain("t1_drain", 20);

    // 2: clean steps 0..3.
    do_reset(5'd0);
    step(5'd0, 4, 1'b0);
    step(5'd1, 4, 1'b1);
    step(5'd2, 4, 1'b1);
    step(5'd3, 4, 1'b1);
    drain("t2_drain", 30);

    // 3: one-cycle transient code between 3 and 4.
    do_reset(5'd3);
    step(5'd3, 4, 1'b0);
    step(5'd5, 1, 1'b0);
    step(5'd4, 4, 1'b1);
    drain("t3_drain", 30);

    // 4: backpressure fills the queue and the sixth address is dropped.
    vec_ready_i = 1'b0;
    do_reset(5'd0);
    step(5'd0, 3, 1'b0);
    step(5'd1, 3, 1'b1);
    step(5'd2, 3, 1'b1);
    step(5'd3, 3, 1'b1);
    step(5'd4, 3, 1'b1);
    chk("t4_ovf_clear", 64'(ovf_o), 64'd0);
    step(5'd5, 3, 1'b0);
    repeat (6) @(posedge clk); #1;
    chk("t4_ovf_set",     64'(ovf_o),       64'd1);
    chk("t4_hold_valid",  64'(vec_valid_o), 64'd1);
    chk("t4_hold_addr",   64'(vec_addr_o),  64'd0);
    vec_ready_i = 1'b1;
    drain("t4_drain", 40);
    chk("t4_ovf_sticky", 64'(ovf_o), 64'd1);

    // 5: ready toggling while the presented index is rewritten.
    vec_ready_i = 1'b0;
    do_reset(5'd5);
    for (int c = 0; c < 28; c++) begin
      if (c == 4) begin addr_i = 5'd6; expect_vec(5'd6); end
      if (c == 8) begin addr_i = 5'd7; expect_vec(5'd7); end
      vec_ready_i = c[0];
      if (vec_valid_o) begin
        nw        = rnd_word();
        wr_en_i   = 1'b1;
        wr_addr_i = vec_addr_o;
        wr_data_i = nw;
        mt[vec_addr_o] = nw;
      end else begin
        wr_en_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    wr_en_i = 1'b0;
    vec_ready_i = 1'b1;
    drain("t5_drain", 30);

    // 6: reset while presenting; the held address is fetched again exactly once.
    vec_ready_i = 1'b0;
    do_reset(5'd2);
    k = 0;
    while (!vec_valid_o && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t6_presenting", 64'(vec_valid_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_async_valid",  64'(vec_valid_o), 64'd0);
    chk("t6_async_addr",   64'(vec_addr_o),  64'd0);
    chk("t6_async_op_a",   64'(op_a_o),      64'd0);
    chk("t6_async_op_b",   64'(op_b_o),      64'd0);
    chk("t6_async_opcode", 64'(opcode_o),    64'd0);
    exp_q.delete();
    expect_vec(5'd2);
    repeat (2) @(posedge clk); #1;
    base = n_hs;
    vec_ready_i = 1'b1;
    rst = 1'b1;
    drain("t6_drain", 30);
    chk("t6_refetch_once", 64'(n_hs - base), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
